// File: rtl/st7735_pattern_gen_pkg.sv
// Shared definitions for the ST7735 pixel source: frame defaults, the
// RGB565 colours used by the bar pattern, mode encodings and FSM states.
package st7735_pkg;

    // Panel geometry used when a parent does not override it
    localparam int DEFAULT_WIDTH  = 128;
    localparam int DEFAULT_HEIGHT = 160;

    // RGB565 colours, {R[4:0], G[5:0], B[4:0]}
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Pattern selection as driven on the mode input
    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } pattern_mode_t;

    // Frame sequencer states
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } gen_state_t;

    // Classic colour-bar order, brightest on the left, black on the right
    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] c;
        case (bar)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/st7735_pattern_gen_if.sv
// Pixel stream between the pattern generator and the ST7735 driver.
// The generator is the master; a transfer happens when valid and ready
// are both high on a rising clock edge.
interface st7735_pattern_gen_if;

    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        first;
    logic        last;

    modport master (
        output data,
        output valid,
        output first,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  first,
        input  last,
        output ready
    );

endinterface

// File: rtl/st7735_pattern_color.sv
// Registered colour lookup. The parent presents the coordinates of the
// pixel it is about to show and pulses load; the colour appears on the
// output register one clock later, so the pixel bus is never combinational.
module st7735_pattern_color
    import st7735_pkg::*;
#(
    parameter int          WIDTH       = DEFAULT_WIDTH,
    parameter logic [15:0] SOLID_COLOR = RGB_RED,
    parameter int          CHECK_SHIFT = 3,
    parameter int          XW          = 7,
    parameter int          YW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  pattern_mode_t mode,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [4:0]    frame_cnt,
    output logic [15:0]   color
);

    // Bars are WIDTH/8 pixels wide; anything past the eighth bar stays on
    // the last (black) bar when WIDTH is not a multiple of eight.
    localparam int BAR_W = (WIDTH >= 8) ? (WIDTH / 8) : 1;

    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic [31:0] bar_idx;
    logic [2:0]  bar;
    logic [15:0] next_color;

    // Colour of the pixel at (x, y) for the selected pattern. Coordinates
    // are widened first so the gradient fields and checker bit can be taken
    // at fixed positions regardless of the frame geometry.
    always_comb begin
        x_ext      = 32'(x);
        y_ext      = 32'(y);
        bar_idx    = x_ext / BAR_W;
        bar        = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
        next_color = SOLID_COLOR;
        case (mode)
            MODE_SOLID: begin
                next_color = SOLID_COLOR;
            end
            MODE_BARS: begin
                next_color = bar_color(bar);
            end
            MODE_CHECKER: begin
                next_color = ((((x_ext >> CHECK_SHIFT) ^ (y_ext >> CHECK_SHIFT)) & 32'd1) != 32'd0)
                             ? RGB_WHITE : RGB_BLACK;
            end
            MODE_GRADIENT: begin
                next_color = {x_ext[6:2], y_ext[7:2], frame_cnt};
            end
            default: begin
                next_color = SOLID_COLOR;
            end
        endcase
    end

    // Output register: updated only when the parent moves to a new pixel,
    // so the colour holds while the driver stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            color <= '0;
        end else if (load) begin
            color <= next_color;
        end
    end

endmodule

// File: rtl/st7735_pattern_gen.sv
// Test-pattern pixel source for the ST7735 driver. A frame request streams
// WIDTH x HEIGHT RGB565 pixels in raster order over a valid/ready handshake.
// Every output is registered; ready only ever feeds flop inputs.
module st7735_pattern_gen
    import st7735_pkg::*;
#(
    parameter int          WIDTH       = DEFAULT_WIDTH,
    parameter int          HEIGHT      = DEFAULT_HEIGHT,
    parameter logic [15:0] SOLID_COLOR = 16'hF800,
    parameter int          CHECK_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_req,
    input  logic [1:0]                mode,
    output logic                      busy,
    output logic                      frame_done,
    st7735_pattern_gen_if.master      pix
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    gen_state_t    state;
    pattern_mode_t mode_r;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [4:0]    frame_cnt;
    logic          pending;
    logic          valid_r;
    logic          first_r;
    logic          last_r;
    logic          busy_r;
    logic          done_r;

    logic          xfer;
    logic          start;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          load;
    logic [XW-1:0] ld_x;
    logic [YW-1:0] ld_y;
    pattern_mode_t ld_mode;
    logic [15:0]   color_q;

    // Handshake decode, raster successor of the current pixel, and the
    // coordinates/mode handed to the colour lookup. On a frame start the
    // lookup gets (0,0) with the live mode input so the first pixel is
    // ready the very next cycle; otherwise it gets the successor pixel.
    always_comb begin
        xfer  = valid_r & pix.ready;
        start = (state == ST_IDLE) & (frame_req | pending);
        if (x == X_MAX) begin
            nx = '0;
            ny = y + YW'(1);
        end else begin
            nx = x + XW'(1);
            ny = y;
        end
        load    = start | (xfer & ~last_r);
        ld_x    = start ? '0 : nx;
        ld_y    = start ? '0 : ny;
        ld_mode = start ? pattern_mode_t'(mode) : mode_r;
    end

    st7735_pattern_color #(
        .WIDTH       (WIDTH),
        .SOLID_COLOR (SOLID_COLOR),
        .CHECK_SHIFT (CHECK_SHIFT),
        .XW          (XW),
        .YW          (YW)
    ) u_color (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .mode      (ld_mode),
        .x         (ld_x),
        .y         (ld_y),
        .frame_cnt (frame_cnt),
        .color     (color_q)
    );

    // Frame sequencer: owns the coordinates, the one-deep request queue,
    // the frame counter and all handshake flags. A request during a frame
    // (including on the final transfer) is remembered and launches the next
    // frame right after frame_done; a reset drops everything immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_SOLID;
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
            pending   <= 1'b0;
            valid_r   <= 1'b0;
            first_r   <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_STREAM;
                        mode_r  <= pattern_mode_t'(mode);
                        x       <= '0;
                        y       <= '0;
                        pending <= 1'b0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        first_r <= 1'b1;
                        last_r  <= (X_MAX == '0) && (Y_MAX == '0);
                    end
                end
                ST_STREAM: begin
                    if (frame_req) begin
                        pending <= 1'b1;
                    end
                    if (xfer) begin
                        if (last_r) begin
                            state     <= ST_IDLE;
                            x         <= '0;
                            y         <= '0;
                            valid_r   <= 1'b0;
                            busy_r    <= 1'b0;
                            first_r   <= 1'b0;
                            last_r    <= 1'b0;
                            done_r    <= 1'b1;
                            frame_cnt <= frame_cnt + 5'd1;
                        end else begin
                            x       <= nx;
                            y       <= ny;
                            first_r <= 1'b0;
                            last_r  <= (nx == X_MAX) && (ny == Y_MAX);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix.data   = color_q;
    assign pix.valid  = valid_r;
    assign pix.first  = first_r;
    assign pix.last   = last_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule
